// File: rtl/uart_loopback_tester.sv
// 8N1 UART exerciser: button-triggered transmitter, receiver with loopback
// select, and an eight-digit hex display of tx/rx bytes and rx/error counts.
module uart_loopback_tester #(
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [7:0]  TX_INIT      = 8'h30
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] btn,
    input  logic       sw0,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] o_seg0,
    output logic [7:0] o_seg1,
    output logic [7:0] o_seg2,
    output logic [7:0] o_seg3,
    output logic [7:0] o_seg4,
    output logic [7:0] o_seg5,
    output logic [7:0] o_seg6,
    output logic [7:0] o_seg7
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    logic unused_btn;
    assign unused_btn = ^btn[4:2];

    // Button chains: [0],[1] synchronize, [2] holds last level for edge detect
    logic [2:0] b0_q, b1_q;
    logic [1:0] rxs_q;
    logic       send_q, clr_q;

    state_t           tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_tick_q, tx_tick_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_sh_q, tx_sh_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             tx_q, tx_d;

    state_t           rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_tick_q, rx_tick_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic [7:0]       rx_count_q, rx_count_d;
    logic [7:0]       err_count_q, err_count_d;

    logic tx_wrap, rx_wrap, rx_src;

    assign tx_wrap = (tx_tick_q == BIT_LAST);
    assign rx_wrap = (rx_tick_q == BIT_LAST);
    // Loopback taps the registered tx output directly; it is already in this domain
    assign rx_src  = sw0 ? tx_q : rxs_q[1];
    assign uart_tx = tx_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            b0_q        <= '0;
            b1_q        <= '0;
            rxs_q       <= 2'b11;
            send_q      <= 1'b0;
            clr_q       <= 1'b0;
            tx_state_q  <= ST_IDLE;
            tx_tick_q   <= '0;
            tx_bit_q    <= '0;
            tx_sh_q     <= '0;
            tx_byte_q   <= TX_INIT;
            tx_q        <= 1'b1;
            rx_state_q  <= ST_IDLE;
            rx_tick_q   <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            rx_byte_q   <= '0;
            rx_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            b0_q        <= {b0_q[1:0], btn[0]};
            b1_q        <= {b1_q[1:0], btn[1]};
            rxs_q       <= {rxs_q[0], uart_rx};
            send_q      <= b0_q[1] & ~b0_q[2];
            clr_q       <= b1_q[1] & ~b1_q[2];
            tx_state_q  <= tx_state_d;
            tx_tick_q   <= tx_tick_d;
            tx_bit_q    <= tx_bit_d;
            tx_sh_q     <= tx_sh_d;
            tx_byte_q   <= tx_byte_d;
            tx_q        <= tx_d;
            rx_state_q  <= rx_state_d;
            rx_tick_q   <= rx_tick_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            rx_byte_q   <= rx_byte_d;
            rx_count_q  <= rx_count_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            ST_IDLE:  if (send_q)                      tx_state_d = ST_START;
            ST_START: if (tx_wrap)                     tx_state_d = ST_DATA;
            ST_DATA:  if (tx_wrap && tx_bit_q == 3'd7) tx_state_d = ST_STOP;
            ST_STOP:  if (tx_wrap)                     tx_state_d = ST_IDLE;
            default:                                   tx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_tick_d = (tx_state_q == ST_IDLE || tx_wrap) ? '0 : tx_tick_q + CNT_W'(1);
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        tx_byte_d = tx_byte_q;
        if (tx_state_q == ST_IDLE && send_q) begin
            tx_sh_d   = tx_byte_q;
            tx_byte_d = tx_byte_q + 8'd1;
            tx_bit_d  = 3'd0;
        end
        if (tx_state_q == ST_DATA && tx_wrap) begin
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_bit_d = tx_bit_q + 3'd1;
        end
        unique case (tx_state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = tx_sh_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            ST_IDLE:  if (!rx_src)                     rx_state_d = ST_START;
            ST_START: if (rx_tick_q == HALF_LAST)      rx_state_d = rx_src ? ST_IDLE : ST_DATA;
            ST_DATA:  if (rx_wrap && rx_bit_q == 3'd7) rx_state_d = ST_STOP;
            ST_STOP:  if (rx_wrap)                     rx_state_d = ST_IDLE;
            default:                                   rx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_tick_d   = (rx_state_q == ST_IDLE || rx_state_d != rx_state_q || rx_wrap)
                      ? '0 : rx_tick_q + CNT_W'(1);
        rx_bit_d    = (rx_state_q == ST_IDLE) ? 3'd0 : rx_bit_q;
        rx_sh_d     = rx_sh_q;
        rx_byte_d   = rx_byte_q;
        rx_count_d  = rx_count_q;
        err_count_d = err_count_q;
        if (rx_state_q == ST_DATA && rx_wrap) begin
            rx_sh_d  = {rx_src, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
        end
        if (rx_state_q == ST_STOP && rx_wrap) begin
            if (rx_src) begin
                rx_byte_d  = rx_sh_q;
                rx_count_d = rx_count_q + 8'd1;
            end else if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
        if (clr_q) begin
            rx_byte_d   = '0;
            rx_count_d  = '0;
            err_count_d = '0;
        end
    end

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'h03;  4'h1: hex7 = 8'h9F;  4'h2: hex7 = 8'h25;  4'h3: hex7 = 8'h0D;
            4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h49;  4'h6: hex7 = 8'h41;  4'h7: hex7 = 8'h1F;
            4'h8: hex7 = 8'h01;  4'h9: hex7 = 8'h09;  4'hA: hex7 = 8'h11;  4'hB: hex7 = 8'hC1;
            4'hC: hex7 = 8'h63;  4'hD: hex7 = 8'h85;  4'hE: hex7 = 8'h61;  default: hex7 = 8'h71;
        endcase
    endfunction

    assign o_seg0 = hex7(tx_byte_q[3:0]);
    assign o_seg1 = hex7(tx_byte_q[7:4]);
    assign o_seg2 = hex7(rx_byte_q[3:0]);
    assign o_seg3 = hex7(rx_byte_q[7:4]);
    assign o_seg4 = hex7(rx_count_q[3:0]);
    assign o_seg5 = hex7(rx_count_q[7:4]);
    assign o_seg6 = hex7(err_count_q[3:0]);
    assign o_seg7 = hex7(err_count_q[7:4]);

endmodule

// File: tb/tb_uart_loopback_tester.sv
// Directed + randomized bench for uart_loopback_tester against a byte-level
// model of the tx/rx registers and counters.
module tb_uart_loopback_tester;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] btn;
    logic       sw0;
    logic       uart_rx;
    logic       uart_tx;
    logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

    uart_loopback_tester #(.CLKS_PER_BIT(CPB), .TX_INIT(8'h30)) dut (
        .clk(clk), .resetn(resetn), .btn(btn), .sw0(sw0),
        .uart_rx(uart_rx), .uart_tx(uart_tx),
        .o_seg0(seg0), .o_seg1(seg1), .o_seg2(seg2), .o_seg3(seg3),
        .o_seg4(seg4), .o_seg5(seg5), .o_seg6(seg6), .o_seg7(seg7)
    );

    always #5 clk = ~clk;

    logic [7:0] font [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                              8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    // Reference model state
    logic [7:0] m_tx, m_rxb, m_rxc, m_err;
    int n_pass = 0, n_fail = 0, n_total = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tx = 8'h30; m_rxb = 8'h00; m_rxc = 8'h00; m_err = 8'h00;
    endtask

    task automatic check_disp(input string step);
        check({step, " seg0"}, seg0, font[m_tx[3:0]]);
        check({step, " seg1"}, seg1, font[m_tx[7:4]]);
        check({step, " seg2"}, seg2, font[m_rxb[3:0]]);
        check({step, " seg3"}, seg3, font[m_rxb[7:4]]);
        check({step, " seg4"}, seg4, font[m_rxc[3:0]]);
        check({step, " seg5"}, seg5, font[m_rxc[7:4]]);
        check({step, " seg6"}, seg6, font[m_err[3:0]]);
        check({step, " seg7"}, seg7, font[m_err[7:4]]);
        $display("step %s: tx=%02h rx=%02h cnt=%02h err=%02h", step, m_tx, m_rxb, m_rxc, m_err);
    endtask

    // Leaves the bench just after the negedge following the 2nd posedge of the press
    task automatic press(input int idx);
        @(negedge clk) btn[idx] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) btn[idx] = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        if (stop_bit) begin
            m_rxb = b;
            m_rxc = m_rxc + 8'd1;
        end else if (m_err != 8'hFF) begin
            m_err = m_err + 8'd1;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] sent, rb;
        logic       exp_bit, sb;

        resetn = 1'b0; btn = '0; sw0 = 1'b0; uart_rx = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check("reset uart_tx", {7'd0, uart_tx}, 8'h01);
        check_disp("reset_held");
        @(negedge clk) resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_disp("after_reset");

        // Loopback send, with frame shape checked at every bit midpoint
        sw0 = 1'b1;
        sent = m_tx;
        press(0);
        @(posedge clk) #1 check("send edge3 idle", {7'd0, uart_tx}, 8'h01);
        @(posedge clk) #1 check("send edge4 start", {7'd0, uart_tx}, 8'h00);
        m_tx = m_tx + 8'd1;
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? CPB / 2 : CPB) @(posedge clk);
            exp_bit = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : sent[i-1];
            #1 check($sformatf("frame bit%0d", i), {7'd0, uart_tx}, {7'd0, exp_bit});
        end
        repeat (3 * CPB) @(posedge clk);
        m_rxb = sent; m_rxc = m_rxc + 8'd1;
        #1 check_disp("loopback_30");

        // Second press mid-frame must be dropped
        sent = m_tx;
        press(0);
        repeat (40) @(posedge clk);
        press(0);
        repeat (14 * CPB) @(posedge clk);
        m_tx = m_tx + 8'd1;
        m_rxb = sent; m_rxc = m_rxc + 8'd1;
        #1 check_disp("busy_drop");
        check("idle after frame", {7'd0, uart_tx}, 8'h01);

        // External receive: fixed pattern then random bytes/stop bits
        @(negedge clk) sw0 = 1'b0;
        repeat (4) @(negedge clk);
        drive_frame(8'hA5, 1'b1);
        #1 check_disp("ext_A5");
        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            drive_frame(rb, sb);
            #1 check_disp($sformatf("ext_rand%0d", k));
        end

        drive_frame(8'h5A, 1'b0);
        #1 check_disp("stop_error");

        @(negedge clk) uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        #1 check_disp("glitch");

        press(1);
        repeat (4) @(posedge clk);
        m_rxb = 8'h00; m_rxc = 8'h00; m_err = 8'h00;
        #1 check_disp("clear");

        // Asynchronous reset in the middle of a loopback frame
        @(negedge clk) sw0 = 1'b1;
        press(0);
        repeat (2) @(posedge clk);
        repeat (5) @(posedge clk);
        #1 check("mid-frame low", {7'd0, uart_tx}, 8'h00);
        #2 resetn = 1'b0;
        #1 check("async reset tx", {7'd0, uart_tx}, 8'h01);
        model_reset();
        check_disp("async_reset");
        @(negedge clk) resetn = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1 check("post-reset idle", {7'd0, uart_tx}, 8'h01);
        check_disp("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_loopback_tester.md
Name: uart_loopback_tester

Overview:
Self-contained UART exerciser for the NVBoard top level. It contains an 8N1 transmitter and receiver. A push-button sends a byte, and a switch selects internal loopback or the external rx pin. Transmitted, received and status values are shown as hex on eight 7-segment digits.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit (must be an even number, at least 4); the half-bit point is CLKS_PER_BIT/2.
TX_INIT, 8'h30, value of the tx byte register after reset.

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
btn  in  5  push-buttons, active-high; btn[0]=send, btn[1]=clear stats, btn[4:2] unused
sw0  in  1  1 = internal loopback (rx fed from own uart_tx), 0 = external uart_rx
uart_rx  in  1  external serial input, idle high
uart_tx  out  1  serial output, idle high
o_seg0..o_seg7  out  8 each  active-low digits: bit7=a, bit6=b, ... bit1=g, bit0=dp; dp always off (1)

Behaviour:
- Reset (resetn=0, asynchronous), all of:
  - uart_tx=1; tx_byte=TX_INIT; rx_byte=0; rx_cnt=0; err_cnt=0.
  - Both FSMs in IDLE.
  - Synchronizer flops are set to their idle levels: btn flops to 0, rx flops to 1.
- Input sync:
  - btn[0] and btn[1] each pass through 2 flops, then a 3rd flop for edge detection; rising edge gives a 1-cycle pulse.
  - uart_rx passes through 2 flops.
  - Loopback path: the rx source is mux(sw0, uart_tx, uart_rx_sync). uart_tx is registered, so it needs no sync.
- Send:
  - A send pulse while TX is IDLE starts a frame carrying tx_byte.
  - uart_tx goes low on the clk edge after the pulse, i.e. the 4th rising edge after btn[0] rises.
  - tx_byte increments by 1 (mod 256) when the frame starts.
  - A send pulse while TX is busy is dropped; there is no queue.
- TX FSM: IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> IDLE.
  - Each bit lasts exactly CLKS_PER_BIT cycles; a frame is 10*CLKS_PER_BIT cycles.
  - A new frame may start the cycle after STOP ends.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE -> START when synced rx is 0.
  - START: wait CLKS_PER_BIT/2 cycles. If rx is 1 there (false start), return to IDLE; otherwise continue.
  - DATA: sample 8 bits at CLKS_PER_BIT intervals from the start midpoint, LSB first.
  - STOP: sample the stop bit one CLKS_PER_BIT later.
    - Stop bit = 1: rx_byte <= shifted data; rx_cnt+1 (wraps mod 256).
    - Stop bit = 0: rx_byte unchanged; err_cnt+1, saturating at 8'hFF.
    - Either way, return to IDLE on the next cycle; a new start edge may be detected immediately.
- Clear pulse (btn[1]) sets rx_cnt=0, err_cnt=0, rx_byte=0. It does not change tx_byte or FSM state.
  - If a clear coincides with an rx_cnt or err_cnt update, clear wins.
- Switching sw0 mid-frame is allowed. A frame corrupted this way is counted as error or ignored per the rules above, with no lockup.
- Display, high nibble on the odd-numbered digit, combinational from registers:
  - o_seg1:o_seg0 = tx_byte (next byte to send).
  - o_seg3:o_seg2 = rx_byte.
  - o_seg5:o_seg4 = rx_cnt.
  - o_seg7:o_seg6 = err_cnt.
- Hex font, active-low (segment abcdefg lit = 0, dp=1):
  - 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F
  - 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71

Test Plan:
1. Reset with defaults -> uart_tx=1; o_seg1=0D, o_seg0=03 ("30"); o_seg2..o_seg7 all 03.
2. sw0=1, btn[0] pulse -> uart_tx low at the 4th edge. Frame bits 0,0,0,0,0,1,1,0,0,1 at 16 clks each. After the stop sample: rx_byte=30, rx_cnt=01, tx_byte=31 (o_seg0=9F).
3. Second btn[0] pulse mid-frame -> ignored; exactly one frame sent; tx_byte advances only once.
4. sw0=0, drive uart_rx with an 8'hA5 frame -> rx_byte=A5 (o_seg3=11, o_seg2=49); rx_cnt increments.
5. Drive uart_rx with a frame whose stop bit is 0 -> err_cnt=01, rx_byte unchanged. A 4-clk low glitch on uart_rx -> no count change.
6. btn[1] pulse -> rx_cnt, err_cnt and rx_byte read 00; tx_byte kept. Assert resetn=0 mid-TX-frame -> uart_tx=1 immediately.
